// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-4 FFT datapath and its output
// serializer: frame geometry, complex sample type and digit reversal.
package fft_pkg;

  localparam int FFT_N = 16;
  localparam int FFT_W = 16;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  // Serializer control state, kept as one struct so it can be observed whole.
  typedef struct packed {
    logic [1:0] full;
    logic       wsel;
    logic       rsel;
    logic [3:0] cnt;
    logic       overflow;
  } ser_state_t;

  // Radix-4 digit reversal of a 4-bit index: swap the two 2-bit digits.
  function automatic logic [3:0] digit_rev4(input logic [3:0] idx);
    return {idx[1:0], idx[3:2]};
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One 16-entry complex register bank: parallel load of a whole frame,
// indexed combinational read of a single slot.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int W = FFT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [FFT_N*W-1:0] wr_re,
  input  logic [FFT_N*W-1:0] wr_im,
  input  logic [3:0]       rd_slot,
  output logic [W-1:0]     rd_re,
  output logic [W-1:0]     rd_im
);

  logic [W-1:0] mem_re [FFT_N];
  logic [W-1:0] mem_im [FFT_N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FFT_N; k++) begin
        mem_re[k] <= '0;
        mem_im[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < FFT_N; k++) begin
        mem_re[k] <= wr_re[k*W +: W];
        mem_im[k] <= wr_im[k*W +: W];
      end
    end
  end

  assign rd_re = mem_re[rd_slot];
  assign rd_im = mem_im[rd_slot];

endmodule

// File: rtl/fft_out_serializer.sv
// Captures parallel 16-bin FFT frames into a ping-pong buffer and streams the
// bins out in natural order; frames arriving with both banks occupied are dropped.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int W         = FFT_W,
  parameter bit DIGIT_REV = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [FFT_N*W-1:0] in_re,
  input  logic [FFT_N*W-1:0] in_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_re,
  output logic [W-1:0]       out_im,
  output logic [3:0]         out_idx,
  output logic               out_last,
  output logic               overflow,
  output logic               busy
);

  ser_state_t   st;
  ser_state_t   st_nx;
  logic [3:0]   rd_slot;
  logic         xfer;
  logic         rel;
  logic         wfree;
  logic         capture;
  logic         drop;
  logic [W-1:0] re_b0;
  logic [W-1:0] im_b0;
  logic [W-1:0] re_b1;
  logic [W-1:0] im_b1;

  // out_valid/out_ready: a bin transfers on any rising edge where both are
  // high; until then out_valid, out_re/out_im, out_idx and out_last hold.
  assign xfer    = st.full[st.rsel] & out_ready;
  assign rel     = xfer & (st.cnt == 4'd15);
  // A bank draining its last bin this cycle may be refilled on the same edge.
  assign wfree   = ~st.full[st.wsel] | (rel & (st.rsel == st.wsel));
  assign capture = in_valid & wfree;
  assign drop    = in_valid & ~wfree;

  always_comb begin
    st_nx = st;
    if (xfer) st_nx.cnt = st.cnt + 4'd1;
    if (rel) begin
      st_nx.full[st.rsel] = 1'b0;
      st_nx.rsel          = ~st.rsel;
    end
    // Applied after the release so a same-bank capture leaves the bank full.
    if (capture) begin
      st_nx.full[st.wsel] = 1'b1;
      st_nx.wsel          = ~st.wsel;
    end
    if (drop) st_nx.overflow = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= '0;
    else       st <= st_nx;
  end

  assign rd_slot = DIGIT_REV ? digit_rev4(st.cnt) : st.cnt;

  fft_frame_bank #(.W(W)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .load    (capture & ~st.wsel),
    .wr_re   (in_re),
    .wr_im   (in_im),
    .rd_slot (rd_slot),
    .rd_re   (re_b0),
    .rd_im   (im_b0)
  );

  fft_frame_bank #(.W(W)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .load    (capture & st.wsel),
    .wr_re   (in_re),
    .wr_im   (in_im),
    .rd_slot (rd_slot),
    .rd_re   (re_b1),
    .rd_im   (im_b1)
  );

  assign out_valid = st.full[st.rsel];
  assign out_re    = st.rsel ? re_b1 : re_b0;
  assign out_im    = st.rsel ? im_b1 : im_b0;
  assign out_idx   = st.cnt;
  assign out_last  = (st.cnt == 4'd15);
  assign overflow  = st.overflow;
  assign busy      = |st.full;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Scoreboard bench for fft_out_serializer: one natural-order and one
// digit-reversed instance share stimulus and are checked against a frame model.
module tb_fft_out_serializer;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int EW = 4 + 2*W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           in_valid;
  logic [N*W-1:0] in_re;
  logic [N*W-1:0] in_im;
  logic           out_ready;

  logic         v0, last0, ovf0, busy0;
  logic [W-1:0] re0, im0;
  logic [3:0]   idx0;
  logic         v1, last1, ovf1, busy1;
  logic [W-1:0] re1, im1;
  logic [3:0]   idx1;

  fft_out_serializer #(.W(W), .DIGIT_REV(1'b0)) dut_nat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(v0), .out_ready(out_ready), .out_re(re0), .out_im(im0),
    .out_idx(idx0), .out_last(last0), .overflow(ovf0), .busy(busy0)
  );

  fft_out_serializer #(.W(W), .DIGIT_REV(1'b1)) dut_rev (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(v1), .out_ready(out_ready), .out_re(re1), .out_im(im1),
    .out_idx(idx1), .out_last(last1), .overflow(ovf1), .busy(busy1)
  );

  // ---------------- model / scoreboard state ----------------
  // Expected beats, oldest first: {natural index, re, im}.
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic          model_ovf = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            ready_mode = 0;  // 0: hold low, 1: hold high, 2: random
  logic [W-1:0]  frame_re [N];
  logic [W-1:0]  frame_im [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_nat_valid"}, 64'(v0), 0);
    chk({tag, "_nat_re"},    64'(re0), 0);
    chk({tag, "_nat_im"},    64'(im0), 0);
    chk({tag, "_nat_idx"},   64'(idx0), 0);
    chk({tag, "_nat_last"},  64'(last0), 0);
    chk({tag, "_nat_ovf"},   64'(ovf0), 0);
    chk({tag, "_nat_busy"},  64'(busy0), 0);
    chk({tag, "_rev_valid"}, 64'(v1), 0);
    chk({tag, "_rev_re"},    64'(re1), 0);
    chk({tag, "_rev_im"},    64'(im1), 0);
    chk({tag, "_rev_idx"},   64'(idx1), 0);
    chk({tag, "_rev_last"},  64'(last1), 0);
    chk({tag, "_rev_ovf"},   64'(ovf1), 0);
    chk({tag, "_rev_busy"},  64'(busy1), 0);
  endtask

  task automatic cmp_dut(input string tag, input logic valid, input logic [W-1:0] re,
                         input logic [W-1:0] im, input logic [3:0] idx, input logic last,
                         input logic ovf, input logic bsy, input logic has_exp,
                         input logic [EW-1:0] e);
    chk({tag, "_valid"}, 64'(valid), 64'(has_exp));
    chk({tag, "_busy"},  64'(bsy), 64'(has_exp));
    chk({tag, "_ovf"},   64'(ovf), 64'(model_ovf));
    if (has_exp && valid) begin
      chk({tag, "_idx"},  64'(idx), 64'(e[EW-1 -: 4]));
      chk({tag, "_re"},   64'(re), 64'(e[2*W-1 -: W]));
      chk({tag, "_im"},   64'(im), 64'(e[W-1:0]));
      chk({tag, "_last"}, 64'(last), 64'(e[EW-1 -: 4] == 4'd15));
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e0;
    logic [EW-1:0] e1;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_nat_valid", 64'(v0), 0);
        chk("rst_rev_valid", 64'(v1), 0);
      end else begin
        e0 = (exp_q0.size() > 0) ? exp_q0[0] : '0;
        e1 = (exp_q1.size() > 0) ? exp_q1[0] : '0;
        cmp_dut("nat", v0, re0, im0, idx0, last0, ovf0, busy0, exp_q0.size() > 0, e0);
        cmp_dut("rev", v1, re1, im1, idx1, last1, ovf1, busy1, exp_q1.size() > 0, e1);
        // The bin shown now transfers at the coming edge if the consumer is ready.
        if (out_ready) begin
          if (exp_q0.size() > 0) void'(exp_q0.pop_front());
          if (exp_q1.size() > 0) void'(exp_q1.pop_front());
        end
      end
    end
  end

  // ---------------- consumer ready driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  // kind 0: re = k, im = -k; kind 1: re = slot, im = random; otherwise random.
  task automatic load_frame(input int kind);
    for (int k = 0; k < N; k++) begin
      case (kind)
        0:       begin frame_re[k] = W'(k); frame_im[k] = W'(0 - k); end
        1:       begin frame_re[k] = W'(k); frame_im[k] = W'($urandom); end
        default: begin frame_re[k] = W'($urandom); frame_im[k] = W'($urandom); end
      endcase
    end
  endtask

  // Entered and left just after a rising edge; the strobe is sampled at the next edge.
  task automatic strobe();
    int held;
    for (int k = 0; k < N; k++) begin
      in_re[k*W +: W] = frame_re[k];
      in_im[k*W +: W] = frame_im[k];
    end
    in_valid = 1'b1;
    @(posedge clk);
    // Two frames fit; a frame's bank frees once its last bin has been taken.
    held = (exp_q0.size() + N - 1) / N;
    if (held < 2) begin
      for (int k = 0; k < N; k++) begin
        int slot_rev;
        slot_rev = (k % 4) * 4 + k / 4;
        exp_q0.push_back({4'(k), frame_re[k], frame_im[k]});
        exp_q1.push_back({4'(k), frame_re[slot_rev], frame_im[slot_rev]});
      end
    end else begin
      model_ovf = 1'b1;
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q0.size() > 0 && i < 3000) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (exp_q0.size() > 0) bound_fail("drain");
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_zero(tag);
    exp_q0.delete();
    exp_q1.delete();
    model_ovf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus sequence ----------------
  initial begin
    int i;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("por");
    reset = 1'b0;
    idle(2);

    // Ramp frame, consumer always ready.
    ready_mode = 1;
    load_frame(0);
    strobe();
    drain();
    idle(3);

    // Slot-numbered frame exercises the digit-reversed read order.
    load_frame(1);
    strobe();
    drain();
    idle(2);

    // Three frames under a 50% ready consumer.
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      load_frame(2);
      strobe();
      idle($urandom_range(0, 20));
    end
    drain();
    idle(2);

    // Stalled consumer, three back-to-back strobes: the third is dropped.
    ready_mode = 0;
    idle(2);
    for (int f = 0; f < 3; f++) begin
      load_frame(2);
      strobe();
    end
    idle(6);
    ready_mode = 1;
    drain();
    idle(4);
    do_reset("rst_ovf");
    idle(2);

    // Third strobe lands on the last-bin transfer of frame 1: accepted.
    ready_mode = 1;
    idle(2);
    load_frame(2); strobe();
    load_frame(2); strobe();
    idle(14);
    load_frame(2); strobe();
    drain();
    idle(2);

    // Third strobe one cycle before that transfer: dropped.
    load_frame(2); strobe();
    load_frame(2); strobe();
    idle(13);
    load_frame(2); strobe();
    drain();
    idle(2);
    do_reset("rst_ovf2");
    idle(2);

    // Frames every 16 cycles with the consumer always ready.
    for (int f = 0; f < 4; f++) begin
      load_frame(2);
      strobe();
      idle(15);
    end
    drain();
    idle(2);

    // Reset while bin 7 is presented, then a fresh frame.
    load_frame(2);
    strobe();
    i = 0;
    while (!(v0 && idx0 == 4'd7) && i < 40) begin
      idle(1);
      i++;
    end
    if (i >= 40) bound_fail("wait_beat7");
    do_reset("rst_mid");
    idle(2);
    load_frame(0);
    strobe();
    drain();
    idle(2);

    // Random traffic with random consumer, drops allowed.
    ready_mode = 2;
    for (int f = 0; f < 14; f++) begin
      load_frame(2);
      strobe();
      idle($urandom_range(0, 24));
    end
    ready_mode = 1;
    drain();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
